// File: rtl/mem_arbiter_if.sv
// Bus bundle for mem_arbiter: core and loader request channels plus the shared
// single-port memory channel.
interface mem_arbiter_if;
    logic        core_req;
    logic        core_we;
    logic [3:0]  core_wmask;
    logic [31:0] core_addr;
    logic [31:0] core_wdata;
    logic        core_ack;
    logic [31:0] core_rdata;
    logic        core_stall;

    logic        ld_req;
    logic        ld_we;
    logic [3:0]  ld_wmask;
    logic [31:0] ld_addr;
    logic [31:0] ld_wdata;
    logic        ld_ack;
    logic [31:0] ld_rdata;

    logic        mem_en;
    logic        mem_we;
    logic [3:0]  mem_wmask;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    modport slave (
        input  core_req, core_we, core_wmask, core_addr, core_wdata,
        output core_ack, core_rdata, core_stall,
        input  ld_req, ld_we, ld_wmask, ld_addr, ld_wdata,
        output ld_ack, ld_rdata,
        output mem_en, mem_we, mem_wmask, mem_addr, mem_wdata,
        input  mem_rdata
    );

    modport master (
        output core_req, core_we, core_wmask, core_addr, core_wdata,
        input  core_ack, core_rdata, core_stall,
        output ld_req, ld_we, ld_wmask, ld_addr, ld_wdata,
        input  ld_ack, ld_rdata,
        input  mem_en, mem_we, mem_wmask, mem_addr, mem_wdata,
        output mem_rdata
    );
endinterface

// File: rtl/mem_arbiter.sv
// Round-robin arbiter that serialises core and loader accesses onto one
// synchronous single-port memory with a fixed read latency.
module mem_arbiter #(
    parameter int unsigned READ_LATENCY = 1,
    parameter bit          CORE_FIRST   = 1'b1
) (
    input logic          clk,
    input logic          rst,
    mem_arbiter_if.slave bus
);
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;
    typedef enum logic {PORT_CORE, PORT_LD} port_t;

    localparam port_t      LAST_RESET = CORE_FIRST ? PORT_LD : PORT_CORE;
    localparam logic [1:0] WAIT_LOAD  = 2'(READ_LATENCY - 1);

    state_t      state, state_nx;
    port_t       gnt, last, winner;
    logic        grant;
    logic [1:0]  wait_cnt;
    logic        cap_we;
    logic [3:0]  cap_wmask;
    logic [31:0] cap_addr;
    logic [31:0] cap_wdata;

    // On a tie the port that was not granted last time wins.
    always_comb begin
        winner = PORT_CORE;
        if (bus.ld_req && (!bus.core_req || last == PORT_CORE))
            winner = PORT_LD;
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx       = state;
        grant          = 1'b0;
        bus.mem_en     = 1'b0;
        bus.mem_we     = 1'b0;
        bus.mem_wmask  = '0;
        bus.mem_addr   = '0;
        bus.mem_wdata  = '0;
        bus.core_ack   = 1'b0;
        bus.core_rdata = '0;
        bus.ld_ack     = 1'b0;
        bus.ld_rdata   = '0;
        unique case (state)
            IDLE: begin
                if (bus.core_req || bus.ld_req) begin
                    grant    = 1'b1;
                    state_nx = ISSUE;
                end
            end
            ISSUE: begin
                bus.mem_en    = 1'b1;
                bus.mem_we    = cap_we;
                bus.mem_wmask = cap_we ? cap_wmask : '0;
                bus.mem_addr  = cap_addr;
                bus.mem_wdata = cap_wdata;
                state_nx      = (cap_we || READ_LATENCY == 1) ? RESP : WAIT;
            end
            WAIT: begin
                if (wait_cnt == 2'd1) state_nx = RESP;
            end
            RESP: begin
                state_nx = IDLE;
                if (gnt == PORT_CORE) begin
                    bus.core_ack   = 1'b1;
                    bus.core_rdata = cap_we ? '0 : bus.mem_rdata;
                end else begin
                    bus.ld_ack   = 1'b1;
                    bus.ld_rdata = cap_we ? '0 : bus.mem_rdata;
                end
            end
            default: state_nx = IDLE;
        endcase
        bus.core_stall = bus.core_req & ~bus.core_ack;
    end

    // Request fields are captured at grant so later input changes cannot
    // disturb an access already in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            last      <= LAST_RESET;
            gnt       <= PORT_CORE;
            wait_cnt  <= '0;
            cap_we    <= 1'b0;
            cap_wmask <= '0;
            cap_addr  <= '0;
            cap_wdata <= '0;
        end else begin
            if (grant) begin
                gnt  <= winner;
                last <= winner;
                if (winner == PORT_LD) begin
                    cap_we    <= bus.ld_we;
                    cap_wmask <= bus.ld_wmask;
                    cap_addr  <= bus.ld_addr;
                    cap_wdata <= bus.ld_wdata;
                end else begin
                    cap_we    <= bus.core_we;
                    cap_wmask <= bus.core_wmask;
                    cap_addr  <= bus.core_addr;
                    cap_wdata <= bus.core_wdata;
                end
            end
            if (state == ISSUE && state_nx == WAIT)
                wait_cnt <= WAIT_LOAD;
            else if (state == WAIT)
                wait_cnt <= wait_cnt - 2'd1;
        end
    end
endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: four instances (READ_LATENCY 1..4) driven in step,
// each checked every cycle against a transaction-level schedule.
module tb_mem_arbiter;
    localparam int NI   = 4;
    localparam int MAXC = 4096;

    typedef struct packed {
        logic        en;
        logic        we;
        logic [3:0]  mask;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        cack;
        logic [31:0] crd;
        logic        lack;
        logic [31:0] lrd;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic        creq [NI];
    logic        lreq [NI];
    logic        cwe, lwe;
    logic [3:0]  cmask, lmask;
    logic [31:0] caddr, cwdata, laddr, lwdata;

    logic [69:0] obs_mem  [NI];
    logic [33:0] obs_core [NI];
    logic [32:0] obs_ld   [NI];

    exp_t        sched  [NI][MAXC];
    logic [31:0] refmem [NI][32];
    int          free_c [NI];
    int          drop_c [NI][2];
    bit          last_ld [NI];
    int          renew  [2];
    int          cyc, checks, errors;
    int          kind, pulse, gap;

    function automatic logic [31:0] init_word(int k);
        return (k == 16) ? 32'hDEAD_BEEF : 32'h1000_0000 + 32'(k) * 32'h0101_0101;
    endfunction

    for (genvar g = 0; g < NI; g++) begin : g_dut
        localparam int unsigned RL = g + 1;
        mem_arbiter_if bus ();
        logic [31:0] mem  [32];
        logic [31:0] pipe [4];

        mem_arbiter #(.READ_LATENCY(RL), .CORE_FIRST(1'b1)) u_dut (
            .clk (clk),
            .rst (rst),
            .bus (bus)
        );

        assign bus.core_req   = creq[g];
        assign bus.core_we    = cwe;
        assign bus.core_wmask = cmask;
        assign bus.core_addr  = caddr;
        assign bus.core_wdata = cwdata;
        assign bus.ld_req     = lreq[g];
        assign bus.ld_we      = lwe;
        assign bus.ld_wmask   = lmask;
        assign bus.ld_addr    = laddr;
        assign bus.ld_wdata   = lwdata;
        assign bus.mem_rdata  = pipe[RL-1];

        assign obs_mem[g]  = {bus.mem_en, bus.mem_we, bus.mem_wmask, bus.mem_addr, bus.mem_wdata};
        assign obs_core[g] = {bus.core_ack, bus.core_rdata, bus.core_stall};
        assign obs_ld[g]   = {bus.ld_ack, bus.ld_rdata};

        // Synchronous memory: read data appears RL cycles after the enable cycle.
        always @(posedge clk) begin
            if (rst) begin
                for (int k = 0; k < 32; k++) mem[k] <= init_word(k);
                for (int k = 0; k < 4; k++) pipe[k] <= 32'hBADC_0DE0;
            end else begin
                if (bus.mem_en && bus.mem_we)
                    for (int b = 0; b < 4; b++)
                        if (bus.mem_wmask[b])
                            mem[bus.mem_addr[6:2]][8*b +: 8] <= bus.mem_wdata[8*b +: 8];
                pipe[0] <= (bus.mem_en && !bus.mem_we) ? mem[bus.mem_addr[6:2]] : 32'hBADC_0DE0;
                for (int k = 1; k < 4; k++) pipe[k] <= pipe[k-1];
            end
        end
    end

    task automatic plan(int i, bit ld);
        exp_t        e;
        bit          we;
        logic [3:0]  m;
        logic [31:0] a, d;
        int          ack;
        we  = ld ? lwe : cwe;
        m   = ld ? lmask : cmask;
        a   = ld ? laddr : caddr;
        d   = ld ? lwdata : cwdata;
        ack = we ? cyc + 2 : cyc + 2 + i;
        e = '0;
        e.en = 1'b1; e.we = we; e.mask = we ? m : 4'h0; e.addr = a; e.wdata = d;
        sched[i][cyc+1] = e;
        e = '0;
        if (ld) begin e.lack = 1'b1; e.lrd = we ? 32'h0 : refmem[i][a[6:2]]; end
        else    begin e.cack = 1'b1; e.crd = we ? 32'h0 : refmem[i][a[6:2]]; end
        sched[i][ack] = e;
        if (we)
            for (int b = 0; b < 4; b++)
                if (m[b]) refmem[i][a[6:2]][8*b +: 8] = d[8*b +: 8];
        last_ld[i]      = ld;
        free_c[i]       = ack + 1;
        drop_c[i][ld]   = ack + 1;
    endtask

    task automatic model_cycle();
        bit ld;
        for (int i = 0; i < NI; i++) begin
            if (rst) begin
                for (int c = cyc + 1; c < cyc + 8; c++) sched[i][c] = '0;
                for (int k = 0; k < 32; k++) refmem[i][k] = init_word(k);
                free_c[i] = cyc + 1;
                last_ld[i] = 1'b1;
                drop_c[i][0] = -1;
                drop_c[i][1] = -1;
            end else if (cyc >= free_c[i] && (creq[i] || lreq[i])) begin
                ld = lreq[i] && (!creq[i] || !last_ld[i]);
                plan(i, ld);
            end
        end
    endtask

    task automatic check();
        exp_t        e;
        logic [69:0] xm;
        logic [33:0] xc;
        logic [32:0] xl;
        for (int i = 0; i < NI; i++) begin
            e  = sched[i][cyc];
            xm = {e.en, e.we, e.mask, e.addr, e.wdata};
            xc = {e.cack, e.crd, creq[i] & ~e.cack};
            xl = {e.lack, e.lrd};
            checks += 3;
            assert (obs_mem[i] === xm) else begin
                errors++;
                $error("FAIL mem rl%0d cyc%0d got %h want %h", i + 1, cyc, obs_mem[i], xm);
            end
            assert (obs_core[i] === xc) else begin
                errors++;
                $error("FAIL core rl%0d cyc%0d got %h want %h", i + 1, cyc, obs_core[i], xc);
            end
            assert (obs_ld[i] === xl) else begin
                errors++;
                $error("FAIL ld rl%0d cyc%0d got %h want %h", i + 1, cyc, obs_ld[i], xl);
            end
        end
    endtask

    task automatic rand_port(bit ld, bit we);
        logic [31:0] a;
        a = $urandom & 32'hFFFF_FFFC;
        if (ld) begin
            lwe = we; lmask = 4'($urandom_range(0, 15)); laddr = a; lwdata = $urandom;
        end else begin
            cwe = we; cmask = 4'($urandom_range(0, 15)); caddr = a; cwdata = $urandom;
        end
    endtask

    // Requesters drop in the cycle after their ack, optionally presenting a new write.
    task automatic agent();
        bit hit;
        for (int p = 0; p < 2; p++) begin
            hit = 1'b0;
            for (int i = 0; i < NI; i++) if (drop_c[i][p] == cyc) hit = 1'b1;
            if (hit && renew[p] > 0) begin
                renew[p]--;
                rand_port(p[0], 1'b1);
            end else begin
                for (int i = 0; i < NI; i++)
                    if (drop_c[i][p] == cyc) begin
                        if (p == 0) creq[i] = 1'b0;
                        else        lreq[i] = 1'b0;
                    end
            end
        end
    endtask

    task automatic step();
        model_cycle();
        @(negedge clk);
        check();
        @(posedge clk);
        #1;
        cyc++;
        agent();
    endtask

    function automatic bit busy();
        busy = 1'b0;
        for (int i = 0; i < NI; i++)
            if (cyc < free_c[i] || creq[i] || lreq[i]) busy = 1'b1;
    endfunction

    task automatic settle();
        int n;
        n = 0;
        step();
        while (busy() && n < 100) begin
            step();
            n++;
        end
        checks++;
        assert (busy() == 1'b0) else begin
            errors++;
            $error("FAIL settle cyc%0d got busy want idle", cyc);
        end
    endtask

    task automatic drive_core(bit we, logic [3:0] m, logic [31:0] a, logic [31:0] d);
        cwe = we; cmask = m; caddr = a; cwdata = d;
        for (int i = 0; i < NI; i++) creq[i] = 1'b1;
    endtask

    task automatic drive_ld(bit we, logic [3:0] m, logic [31:0] a, logic [31:0] d);
        lwe = we; lmask = m; laddr = a; lwdata = d;
        for (int i = 0; i < NI; i++) lreq[i] = 1'b1;
    endtask

    task automatic clear_reqs();
        for (int i = 0; i < NI; i++) begin
            creq[i] = 1'b0;
            lreq[i] = 1'b0;
        end
    endtask

    initial begin
        rst = 1'b1;
        cyc = 0; checks = 0; errors = 0;
        renew[0] = 0; renew[1] = 0;
        cwe = 0; cmask = '0; caddr = '0; cwdata = '0;
        lwe = 0; lmask = '0; laddr = '0; lwdata = '0;
        clear_reqs();
        for (int i = 0; i < NI; i++) begin
            free_c[i] = 0; last_ld[i] = 1'b1;
            drop_c[i][0] = -1; drop_c[i][1] = -1;
            for (int c = 0; c < MAXC; c++) sched[i][c] = '0;
        end
        @(posedge clk);
        #1;
        repeat (3) step();
        rst = 1'b0;

        drive_core(1'b0, 4'h0, 32'h0000_0040, 32'h0);
        settle();
        drive_ld(1'b1, 4'hF, 32'h0000_0010, 32'h1234_5678);
        settle();
        drive_core(1'b0, 4'hF, 32'h0000_0010, 32'h0);
        settle();
        drive_core(1'b1, 4'h0, 32'h0000_0024, 32'hFFFF_FFFF);
        settle();
        drive_core(1'b1, 4'h5, 32'h0000_0024, 32'hCAFE_F00D);
        settle();
        drive_core(1'b0, 4'h0, 32'h0000_0024, 32'h0);
        settle();

        // Request dropped and inputs scrambled right after grant.
        drive_core(1'b0, 4'h3, 32'h0000_0010, 32'hCAFE_0000);
        step();
        clear_reqs();
        cwe = 1'b1; caddr = 32'h0000_007C; cwdata = $urandom; cmask = 4'hF;
        settle();

        rst = 1'b1;
        repeat (2) step();
        rst = 1'b0;
        renew[0] = 2; renew[1] = 2;
        rand_port(1'b0, 1'b1);
        rand_port(1'b1, 1'b1);
        for (int i = 0; i < NI; i++) begin creq[i] = 1'b1; lreq[i] = 1'b1; end
        settle();

        for (int t = 0; t < 40; t++) begin
            kind  = $urandom_range(0, 3);
            pulse = $urandom_range(0, 3);
            if (kind != 1) begin
                rand_port(1'b0, 1'($urandom_range(0, 1)));
                for (int i = 0; i < NI; i++) creq[i] = 1'b1;
            end
            if (kind != 0) begin
                rand_port(1'b1, 1'($urandom_range(0, 1)));
                for (int i = 0; i < NI; i++) lreq[i] = 1'b1;
            end
            step();
            if (pulse == 0) begin
                clear_reqs();
                rand_port(1'b0, 1'($urandom_range(0, 1)));
                rand_port(1'b1, 1'($urandom_range(0, 1)));
            end
            settle();
            gap = $urandom_range(0, 2);
            repeat (gap) step();
        end

        // Reset while the longer-latency instances are in WAIT.
        drive_core(1'b0, 4'h0, 32'h0000_0040, 32'h0);
        step();
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        clear_reqs();
        repeat (8) step();
        drive_core(1'b1, 4'hF, 32'h0000_0008, 32'hA5A5_5A5A);
        drive_ld(1'b1, 4'h3, 32'h0000_0008, 32'h0000_C3C3);
        settle();
        drive_ld(1'b0, 4'h0, 32'h0000_0008, 32'h0);
        settle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-port memory arbiter and access sequencer that shares the core's single-port synchronous memory between the multicycle core (instruction fetch and load/store) and the program loader/debug port. It serialises accesses, issues each one to memory, waits a fixed read latency, and returns a one-cycle completion pulse. When two ports request in the same cycle it picks one by round-robin. It also stalls the core's control FSM while a core access is outstanding.

## Interface
Parameters:
- READ_LATENCY, 1: cycles from the memory enable cycle to valid `mem_rdata`; legal range 1..4.
- CORE_FIRST, 1: 1 means the core wins the first tie after reset; 0 means the loader wins it.

Ports:
- clk  in  1  sole clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- core_req  in  1  core access request; held until `core_ack`.
- core_we  in  1  1 = write, 0 = read.
- core_wmask  in  4  byte enables for writes.
- core_addr  in  32  byte address.
- core_wdata  in  32  write data.
- core_ack  out  1  one-cycle completion pulse.
- core_rdata  out  32  read data; valid only while `core_ack`=1 for a read.
- core_stall  out  1  `core_req & ~core_ack`.
- ld_req, ld_we, ld_wmask, ld_addr, ld_wdata  in  1/1/4/32/32  loader request; same rules as the core inputs.
- ld_ack  out  1  loader completion pulse.
- ld_rdata  out  32  loader read data.
- mem_en  out  1  memory access enable.
- mem_we  out  1  memory write enable.
- mem_wmask  out  4  memory byte enables.
- mem_addr  out  32  memory address.
- mem_wdata  out  32  memory write data.
- mem_rdata  in  32  memory read data.

## Operation
- State machine states: IDLE, ISSUE, WAIT, RESP.
- **IDLE.** The block samples `core_req` and `ld_req`.
  - If either request is high, register the winner's grant id plus its we, wmask, addr and wdata, then go to ISSUE.
  - If no request is high, stay in IDLE.
- **Round-robin.** A `last` register holds the port most recently granted.
  - On a tie, the port that is not `last` wins.
  - `last` updates at every grant.
  - Reset value of `last`: loader if CORE_FIRST=1, core if CORE_FIRST=0.
- **ISSUE** lasts exactly one cycle.
  - `mem_en`=1 and `mem_we` = captured we.
  - `mem_addr`, `mem_wdata` and `mem_wmask` come from the captured registers, never from live inputs.
  - On a write, `mem_wmask` = captured wmask; on a read, `mem_wmask` = 0.
  - Write: go to RESP.
  - Read with READ_LATENCY=1: go to RESP.
  - Read with READ_LATENCY>1: load the wait counter with READ_LATENCY−1 and go to WAIT.
- **WAIT.** All `mem_*` outputs are 0. Decrement the counter each cycle; go to RESP on the cycle the counter reaches 1.
- **RESP** lasts exactly one cycle.
  - The granted port's ack = 1.
  - On a read, the granted port's rdata = `mem_rdata`, passed through combinationally.
  - The other port's ack = 0 and its rdata = 0. The granted port's rdata is also 0 on a write.
  - Next state is always IDLE.
- **Captured-request rule.** Once granted, an access always completes, even if the requester drops its request or changes inputs. A request dropped before grant is ignored.
- **Empty write.** A write with wmask=0 still pulses `mem_en` and `ack`.
- **Reset mid-operation.** Go to IDLE immediately. The in-flight access is abandoned with no ack. `last` returns to its reset value.

## Timing
- Reset values: every output is 0; state = IDLE; wait counter = 0.
- Timing is counted with the request first seen high in IDLE at cycle 0:
  - ISSUE (memory access cycle) at cycle 1.
  - Write ack at cycle 2.
  - Read ack at cycle 1+READ_LATENCY.
- Back-to-back:
  - After RESP there is always one IDLE cycle, so the next ISSUE comes at RESP+2.
  - Minimum spacing between issues: 3 cycles for writes, 2+READ_LATENCY cycles for reads.
- A requester deasserts, or presents a new request, in the cycle after its ack. `req` still high in the RESP cycle is never re-granted, because RESP always returns to IDLE.
- `core_stall` is combinational: high from the first cycle `core_req` is asserted through the cycle before `core_ack`, and low in the ack cycle.
- At most one access is outstanding, and at most one of `core_ack`/`ld_ack` is high in any cycle.

## Test plan
- **Single core read.** READ_LATENCY=2. `core_req`, addr 0x40, with memory returning 0xDEADBEEF.
  - `mem_en`=1 with addr 0x40 in cycle 1.
  - `core_ack`=1 and `core_rdata`=0xDEADBEEF in cycle 3.
  - `core_stall`=1 in cycles 0–2.
- **Loader write.** addr 0x10, data 0x12345678, wmask 0xF.
  - `mem_en`=`mem_we`=1 with mask 0xF in cycle 1.
  - `ld_ack` in cycle 2.
  - `core_ack` stays 0 throughout.
- **Simultaneous requests after reset**, CORE_FIRST=1, both held high.
  - Grant order is core, loader, core, loader.
  - Successive ISSUE cycles are 3 apart for writes.
- **Request drop after grant.** Deassert `core_req` in cycle 1. The access completes and `core_ack` still pulses.
- **Reset mid-read.** READ_LATENCY=4. Assert `rst` during WAIT.
  - All outputs are 0 the next cycle and no ack is ever produced.
  - A new request after reset completes normally.
- **Latency sweep.** READ_LATENCY = 1, 3, 4: the read ack arrives at cycles 2, 4 and 5 respectively.
